// File: rtl/xor_par_pkg.sv
// Shared constants and elaboration-time helpers for the xor_par parity tree.
// The helper functions describe the shape of the reduction tree. The top
// level uses them to lay every tree node out in one flat vector.
package xor_par_pkg;

    // Default number of bits reduced by the parity generator.
    localparam int PARITY_WIDTH = 7;

    // Returns the number of nodes alive at a given tree level.
    // Level 0 holds the input bits. Each later level pairs adjacent nodes
    // and carries an odd leftover node through unchanged.
    function automatic int levelCount(input int width, input int level);
        int count;
        count = width;
        for (int i = 0; i < level; i++) begin
            count = (count + 1) / 2;
        end
        return count;
    endfunction

    // Returns the index of the first node of a level in the flat node vector.
    function automatic int levelOffset(input int width, input int level);
        int offset;
        offset = 0;
        for (int i = 0; i < level; i++) begin
            offset = offset + levelCount(width, i);
        end
        return offset;
    endfunction

    // Returns the total node count, from the inputs up to the single root.
    function automatic int totalNodes(input int width);
        return levelOffset(width, $clog2(width) + 1);
    endfunction

endpackage

// File: rtl/xor_par_if.sv
// Signal bundle between a producer of data vectors and the parity generator.
// The master side drives the vector. The slave side (xor_par) returns the
// combinational parity and the registered parity and valid flags.
interface xor_par_if
    import xor_par_pkg::*;
#(
    parameter int WIDTH = PARITY_WIDTH
);

    logic [WIDTH-1:0] a;
    logic             parity;
    logic             parity_q;
    logic             valid_q;

    modport master (
        output a,
        input  parity,
        input  parity_q,
        input  valid_q
    );

    modport slave (
        input  a,
        output parity,
        output parity_q,
        output valid_q
    );

endinterface

// File: rtl/xor_par_xor2_cell.sv
// A single 2-input XOR gate cell, which is the only primitive of the parity tree.
// It is kept as its own module so that every gate in a netlist maps to exactly
// one node of the CGP reference circuit.
module xor2_cell (
    input  logic x,
    input  logic y,
    output logic z
);

    // Drive the XOR of the two inputs.
    assign z = x ^ y;

endmodule

// File: rtl/xor_par.sv
// Even-parity generator built as a balanced tree of xor2_cell instances.
// The top of the tree drives the combinational parity output.
// A single flop stage provides a registered copy and a valid flag.
module xor_par
    import xor_par_pkg::*;
#(
    parameter int WIDTH = PARITY_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    xor_par_if.slave  bus
);

    localparam int DEPTH = $clog2(WIDTH);
    localparam int TOTAL = totalNodes(WIDTH);

    // Flat storage for every tree node. The inputs sit at the bottom and the
    // root sits at TOTAL-1. Every node is consumed by exactly one node of the
    // next level, so the vector has no dead bits.
    logic [TOTAL-1:0] nodes;

    logic parity_d;
    logic valid_d;
    logic parity_q;
    logic valid_q;

    // Level 0 of the tree is the input vector itself.
    assign nodes[WIDTH-1:0] = bus.a;

    // Build each level by pairing adjacent nodes of the level below.
    // An odd leftover node passes through unchanged, and no constants are inserted.
    generate
        for (genvar lvl = 0; lvl < DEPTH; lvl++) begin : gLevel
            localparam int COUNT    = levelCount(WIDTH, lvl);
            localparam int SRC_BASE = levelOffset(WIDTH, lvl);
            localparam int DST_BASE = levelOffset(WIDTH, lvl + 1);

            for (genvar p = 0; p < COUNT / 2; p++) begin : gPair
                xor2_cell uCell (
                    .x (nodes[SRC_BASE + 2 * p]),
                    .y (nodes[SRC_BASE + 2 * p + 1]),
                    .z (nodes[DST_BASE + p])
                );
            end

            if ((COUNT % 2) == 1) begin : gCarry
                assign nodes[DST_BASE + COUNT / 2] = nodes[SRC_BASE + COUNT - 1];
            end
        end
    endgenerate

    // The root of the tree is the parity. Once out of reset, every clock edge
    // captures a real sample, so the valid flag simply latches high.
    assign parity_d = nodes[TOTAL-1];
    assign valid_d  = 1'b1;

    // Capture the parity on each clock edge. Reset clears the outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            parity_q <= parity_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.parity   = parity_d;
    assign bus.parity_q = parity_q;
    assign bus.valid_q  = valid_q;

endmodule

// File: tb/tb_xor_par.sv
// Self-checking bench for xor_par. Expected values come from a loop-based
// reference reduction, are queued when stimulus is applied, and are popped
// when the DUT outputs are sampled.
module tb_xor_par;
    import xor_par_pkg::*;

    logic clk;
    logic rst;

    xor_par_if #(.WIDTH(7))  ifW7  ();
    xor_par_if #(.WIDTH(1))  ifW1  ();
    xor_par_if #(.WIDTH(2))  ifW2  ();
    xor_par_if #(.WIDTH(8))  ifW8  ();
    xor_par_if #(.WIDTH(13)) ifW13 ();

    xor_par #(.WIDTH(7))  dutW7  (.clk(clk), .rst(rst), .bus(ifW7));
    xor_par #(.WIDTH(1))  dutW1  (.clk(clk), .rst(rst), .bus(ifW1));
    xor_par #(.WIDTH(2))  dutW2  (.clk(clk), .rst(rst), .bus(ifW2));
    xor_par #(.WIDTH(8))  dutW8  (.clk(clk), .rst(rst), .bus(ifW8));
    xor_par #(.WIDTH(13)) dutW13 (.clk(clk), .rst(rst), .bus(ifW13));

    logic combQ[$];
    logic regQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Abort the run if it never reaches its summary.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    function automatic logic refParity(input logic [63:0] v, input int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < w; i++) p = p ^ v[i];
        return p;
    endfunction

    task automatic popComb(input string tag, input logic actual);
        if (combQ.size() == 0) checkOutput({tag, "_underflow"}, 64'(combQ.size()), 64'd1);
        else checkOutput(tag, 64'(actual), 64'(combQ.pop_front()));
    endtask

    task automatic popReg(input string tag, input logic actual);
        if (regQ.size() == 0) checkOutput({tag, "_underflow"}, 64'(regQ.size()), 64'd1);
        else checkOutput(tag, 64'(actual), 64'(regQ.pop_front()));
    endtask

    // Drive a new vector on the falling edge and queue its expected parity.
    task automatic applyStimulus(input logic [6:0] v, input bit expectReg);
        @(negedge clk);
        ifW7.a = v;
        combQ.push_back(refParity(64'(v), 7));
        if (expectReg) regQ.push_back(refParity(64'(v), 7));
    endtask

    initial begin
        rst      = 1'b1;
        ifW7.a   = '0;
        ifW1.a   = '0;
        ifW2.a   = '0;
        ifW8.a   = '0;
        ifW13.a  = '0;

        // Reset state, with combinational parity still live during reset.
        @(posedge clk); #1;
        checkOutput("rst_parity_q", 64'(ifW7.parity_q), 64'd0);
        checkOutput("rst_valid_q",  64'(ifW7.valid_q),  64'd0);
        checkOutput("rst_parity_zero", 64'(ifW7.parity), 64'd0);
        applyStimulus(7'h7F, 1'b0);
        #2 popComb("rst_parity_ones", ifW7.parity);
        @(posedge clk); #1;
        checkOutput("rst_hold_valid_q", 64'(ifW7.valid_q), 64'd0);

        // Release reset, then run the exhaustive sweep on both paths.
        @(negedge clk);
        rst = 1'b0;
        for (int v = 0; v < 128; v++) begin
            applyStimulus(7'(v), 1'b1);
            #2;
            popComb("sweep_parity", ifW7.parity);
            checkOutput("sweep_parity_known", 64'($isunknown(ifW7.parity)), 64'd0);
            @(posedge clk); #1;
            popReg("sweep_parity_q", ifW7.parity_q);
            checkOutput("sweep_valid_q", 64'(ifW7.valid_q), 64'd1);
            checkOutput("sweep_parity_q_known", 64'($isunknown(ifW7.parity_q)), 64'd0);
        end

        // Registered path with known vectors.
        applyStimulus(7'h15, 1'b1);
        #2 popComb("reg15_parity", ifW7.parity);
        @(posedge clk); #1;
        popReg("reg15_parity_q", ifW7.parity_q);
        checkOutput("reg15_valid_q", 64'(ifW7.valid_q), 64'd1);
        applyStimulus(7'h33, 1'b1);
        #2 popComb("reg33_parity", ifW7.parity);
        @(posedge clk); #1;
        popReg("reg33_parity_q", ifW7.parity_q);

        // Async reset between edges while parity_q is 1.
        applyStimulus(7'h15, 1'b1);
        #2 popComb("pre_rst_parity", ifW7.parity);
        @(posedge clk); #1;
        popReg("pre_rst_parity_q", ifW7.parity_q);
        @(negedge clk); #2;
        rst    = 1'b1;
        ifW7.a = 7'h01;
        #1;
        checkOutput("async_parity_q", 64'(ifW7.parity_q), 64'd0);
        checkOutput("async_valid_q",  64'(ifW7.valid_q),  64'd0);
        checkOutput("async_parity",   64'(ifW7.parity),   64'd1);
        @(posedge clk); #1;
        checkOutput("async_hold_parity_q", 64'(ifW7.parity_q), 64'd0);

        // Reset release with a=7'h40.
        @(negedge clk);
        ifW7.a = 7'h40;
        rst    = 1'b0;
        #1;
        checkOutput("release_valid_q_before", 64'(ifW7.valid_q), 64'd0);
        @(posedge clk); #1;
        checkOutput("release_valid_q_after",  64'(ifW7.valid_q),  64'd1);
        checkOutput("release_parity_q_after", 64'(ifW7.parity_q), 64'd1);

        // Parameter sweep over the other widths with random vectors.
        for (int n = 0; n < 1000; n++) begin
            ifW1.a  = 1'($urandom);
            ifW2.a  = 2'($urandom);
            ifW8.a  = 8'($urandom);
            ifW13.a = 13'($urandom);
            combQ.push_back(refParity(64'(ifW1.a), 1));
            combQ.push_back(refParity(64'(ifW2.a), 2));
            combQ.push_back(refParity(64'(ifW8.a), 8));
            combQ.push_back(refParity(64'(ifW13.a), 13));
            #2;
            popComb("w1_parity",  ifW1.parity);
            popComb("w2_parity",  ifW2.parity);
            popComb("w8_parity",  ifW8.parity);
            popComb("w13_parity", ifW13.parity);
        end

        // All-ones boundaries for the odd and even widths.
        ifW13.a = '1;
        ifW8.a  = '1;
        ifW1.a  = '1;
        #2;
        checkOutput("w13_all_ones", 64'(ifW13.parity), 64'd1);
        checkOutput("w8_all_ones",  64'(ifW8.parity),  64'd0);
        checkOutput("w1_one",       64'(ifW1.parity),  64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
